// File: rtl/ascon_round_sequencer_if.sv
// Handshake and step bus between an Ascon permutation datapath (master) and
// its round sequencer (slave).
interface ascon_round_sequencer_if #(
    parameter int RndW   = 4,
    parameter int Unroll = 1
);
    logic                  start_i;
    logic [1:0]            mode_i;
    logic [RndW-1:0]       cfg_rounds_i;
    logic                  en_i;
    logic                  abort_i;
    logic                  ready_o;
    logic                  busy_o;
    logic [RndW-1:0]       round_o;
    logic [8*Unroll-1:0]   rc_o;
    logic                  last_o;
    logic                  done_o;
    logic                  cfg_err_o;

    modport slave (
        input  start_i, mode_i, cfg_rounds_i, en_i, abort_i,
        output ready_o, busy_o, round_o, rc_o, last_o, done_o, cfg_err_o
    );

    modport master (
        output start_i, mode_i, cfg_rounds_i, en_i, abort_i,
        input  ready_o, busy_o, round_o, rc_o, last_o, done_o, cfg_err_o
    );
endinterface

// File: rtl/ascon_round_sequencer.sv
// Round sequencer for the Ascon permutation: selectable round count, Unroll
// rounds per enabled step, with start/done handshake, stall and abort.
module ascon_round_sequencer #(
    parameter int MaxRounds = 12,
    parameter int Unroll    = 1,
    parameter int RndW      = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    ascon_round_sequencer_if.slave  bus
);
    // One extra bit keeps round arithmetic free of wrap-around.
    localparam int              CntW  = RndW + 1;
    localparam logic [CntW-1:0] MaxW  = CntW'(MaxRounds);
    localparam logic [CntW-1:0] UnrW  = CntW'(Unroll);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [RndW-1:0] rnd_q, rnd_d;
    logic            done_q, done_d;
    logic            cfg_err_q, cfg_err_d;

    logic [CntW-1:0] n_w;
    logic            n_legal;
    logic [CntW-1:0] rnd_ext;
    logic [CntW-1:0] rnd_step;
    logic            busy_w;
    logic            last_w;

    always_comb begin
        case (bus.mode_i)
            2'b00:   n_w = CntW'(12);
            2'b01:   n_w = CntW'(8);
            2'b10:   n_w = CntW'(6);
            default: n_w = {1'b0, bus.cfg_rounds_i};
        endcase
    end

    assign n_legal  = (n_w != '0) && (n_w <= MaxW) && ((n_w % UnrW) == '0);
    assign rnd_ext  = {1'b0, rnd_q};
    assign rnd_step = rnd_ext + UnrW;
    assign busy_w   = (state_q == RUN);
    assign last_w   = busy_w && (rnd_step == MaxW);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= IDLE;
            rnd_q     <= '0;
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rnd_q     <= rnd_d;
            done_q    <= done_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        rnd_d     = rnd_q;
        done_d    = 1'b0;
        cfg_err_d = 1'b0;
        if (bus.abort_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start_i) begin
                        if (n_legal) begin
                            state_d = RUN;
                            rnd_d   = RndW'(MaxW - n_w);
                        end else begin
                            cfg_err_d = 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (bus.en_i) begin
                        if (last_w) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end else begin
                            rnd_d = RndW'(rnd_step);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Constant for round r is {~r, r} on 4 bits; forced to zero outside RUN.
    wire [8*Unroll-1:0] rc_w;
    for (genvar gi = 0; gi < Unroll; gi++) begin : g_rc
        logic [3:0] r_lo;
        assign r_lo              = 4'(rnd_ext + CntW'(gi));
        assign rc_w[8*gi +: 8]   = busy_w ? {4'hF - r_lo, r_lo} : 8'h00;
    end

    assign bus.ready_o   = (state_q == IDLE);
    assign bus.busy_o    = busy_w;
    assign bus.round_o   = rnd_q;
    assign bus.rc_o      = rc_w;
    assign bus.last_o    = last_w;
    assign bus.done_o    = done_q;
    assign bus.cfg_err_o = cfg_err_q;
endmodule

// File: tb/tb_ascon_round_sequencer.sv
// Scoreboard bench for ascon_round_sequencer with Unroll = 1, 2 and 3 instances.
module tb_ascon_round_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ascon_round_sequencer_if #(.RndW(4), .Unroll(1)) b1();
    ascon_round_sequencer_if #(.RndW(4), .Unroll(2)) b2();
    ascon_round_sequencer_if #(.RndW(4), .Unroll(3)) b3();

    ascon_round_sequencer #(.MaxRounds(12), .Unroll(1), .RndW(4)) u1 (.clk_i(clk), .rst_n_i(rst_n), .bus(b1));
    ascon_round_sequencer #(.MaxRounds(12), .Unroll(2), .RndW(4)) u2 (.clk_i(clk), .rst_n_i(rst_n), .bus(b2));
    ascon_round_sequencer #(.MaxRounds(12), .Unroll(3), .RndW(4)) u3 (.clk_i(clk), .rst_n_i(rst_n), .bus(b3));

    typedef struct packed {
        logic [2:0]  kind;
        logic [3:0]  rnd;
        logic [23:0] rc;
        logic        last;
    } exp_t;

    localparam logic [2:0] K_STEP = 3'b001;
    localparam logic [2:0] K_DONE = 3'b010;
    localparam logic [2:0] K_ERR  = 3'b100;

    localparam logic [7:0] RC_TAB [12] = '{8'hF0, 8'hE1, 8'hD2, 8'hC3, 8'hB4, 8'hA5,
                                           8'h96, 8'h87, 8'h78, 8'h69, 8'h5A, 8'h4B};

    exp_t q1[$];
    exp_t q2[$];
    exp_t q3[$];
    int   errors = 0;
    int   checks = 0;

    function automatic exp_t mk(input logic [2:0] k, input logic [3:0] r,
                                input logic [23:0] rc, input logic l);
        exp_t e;
        e.kind = k;
        e.rnd  = r;
        e.rc   = rc;
        e.last = l;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic compare(input string tag, input logic [2:0] kind, input logic [3:0] rnd,
                           input logic [23:0] rc, input logic last, input exp_t e);
        $display("%s event kind=%b round=%0d rc=%h last=%b (expect kind=%b round=%0d rc=%h last=%b)",
                 tag, kind, rnd, rc, last, e.kind, e.rnd, e.rc, e.last);
        check({tag, " kind"},  32'(kind), 32'(e.kind));
        check({tag, " round"}, 32'(rnd),  32'(e.rnd));
        check({tag, " rc"},    32'(rc),   32'(e.rc));
        check({tag, " last"},  32'(last), 32'(e.last));
    endtask

    task automatic unexpected(input string tag, input logic [2:0] kind, input logic [3:0] rnd);
        checks++;
        errors++;
        $display("FAIL %s unexpected event: got kind=%b round=%0d, required no event", tag, kind, rnd);
    endtask

    // Monitors: any cycle with busy, done or cfg_err is an observable event.
    always @(negedge clk) begin
        if (rst_n && (b1.busy_o || b1.done_o || b1.cfg_err_o)) begin
            if (q1.size() == 0) unexpected("u1", {b1.cfg_err_o, b1.done_o, b1.busy_o}, b1.round_o);
            else compare("u1", {b1.cfg_err_o, b1.done_o, b1.busy_o}, b1.round_o, 24'(b1.rc_o), b1.last_o, q1.pop_front());
        end
    end

    always @(negedge clk) begin
        if (rst_n && (b2.busy_o || b2.done_o || b2.cfg_err_o)) begin
            if (q2.size() == 0) unexpected("u2", {b2.cfg_err_o, b2.done_o, b2.busy_o}, b2.round_o);
            else compare("u2", {b2.cfg_err_o, b2.done_o, b2.busy_o}, b2.round_o, 24'(b2.rc_o), b2.last_o, q2.pop_front());
        end
    end

    always @(negedge clk) begin
        if (rst_n && (b3.busy_o || b3.done_o || b3.cfg_err_o)) begin
            if (q3.size() == 0) unexpected("u3", {b3.cfg_err_o, b3.done_o, b3.busy_o}, b3.round_o);
            else compare("u3", {b3.cfg_err_o, b3.done_o, b3.busy_o}, b3.round_o, 24'(b3.rc_o), b3.last_o, q3.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((q1.size() + q2.size() + q3.size()) != 0 && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if ((q1.size() + q2.size() + q3.size()) != 0) begin
            errors++;
            $display("FAIL %s timeout: got %0d pending expected events, required 0", name,
                     q1.size() + q2.size() + q3.size());
            q1.delete();
            q2.delete();
            q3.delete();
        end
        repeat (3) tick();
    endtask

    task automatic run_p12_u1(input string name);
        b1.mode_i  = 2'b00;
        b1.en_i    = 1'b1;
        b1.start_i = 1'b1;
        for (int r = 0; r < 12; r++) q1.push_back(mk(K_STEP, 4'(r), 24'(RC_TAB[r]), r == 11));
        q1.push_back(mk(K_DONE, 4'd11, 24'h0, 1'b0));
        tick();
        b1.start_i = 1'b0;
        drain(name);
    endtask

    initial begin
        b1.start_i = 0; b1.mode_i = 0; b1.cfg_rounds_i = 0; b1.en_i = 0; b1.abort_i = 0;
        b2.start_i = 0; b2.mode_i = 0; b2.cfg_rounds_i = 0; b2.en_i = 0; b2.abort_i = 0;
        b3.start_i = 0; b3.mode_i = 0; b3.cfg_rounds_i = 0; b3.en_i = 0; b3.abort_i = 0;
        repeat (3) tick();

        // Reset state
        check("rst ready",   32'(b1.ready_o),   32'd1);
        check("rst busy",    32'(b1.busy_o),    32'd0);
        check("rst round",   32'(b1.round_o),   32'd0);
        check("rst rc",      32'(b1.rc_o),      32'd0);
        check("rst last",    32'(b1.last_o),    32'd0);
        check("rst done",    32'(b1.done_o),    32'd0);
        check("rst cfg_err", 32'(b1.cfg_err_o), 32'd0);
        check("rst rc u3",   32'(b3.rc_o),      32'd0);
        rst_n = 1'b1;
        repeat (2) tick();

        // p12, Unroll=1, no stalls
        run_p12_u1("u1_p12");

        // p6, Unroll=1, alternating stall/step
        b1.mode_i  = 2'b10;
        b1.en_i    = 1'b0;
        b1.start_i = 1'b1;
        for (int r = 6; r < 12; r++) begin
            q1.push_back(mk(K_STEP, 4'(r), 24'(RC_TAB[r]), r == 11));
            q1.push_back(mk(K_STEP, 4'(r), 24'(RC_TAB[r]), r == 11));
        end
        q1.push_back(mk(K_DONE, 4'd11, 24'h0, 1'b0));
        tick();
        b1.start_i = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            b1.en_i = ~b1.en_i;
        end
        b1.en_i = 1'b1;
        drain("u1_p6_stall");

        // p8, Unroll=2
        b2.mode_i  = 2'b01;
        b2.en_i    = 1'b1;
        b2.start_i = 1'b1;
        q2.push_back(mk(K_STEP, 4'd4,  24'h00A5B4, 1'b0));
        q2.push_back(mk(K_STEP, 4'd6,  24'h008796, 1'b0));
        q2.push_back(mk(K_STEP, 4'd8,  24'h006978, 1'b0));
        q2.push_back(mk(K_STEP, 4'd10, 24'h004B5A, 1'b1));
        q2.push_back(mk(K_DONE, 4'd10, 24'h0, 1'b0));
        tick();
        b2.start_i = 1'b0;
        drain("u2_p8");

        // Unroll=3: illegal counts 8, 0, 13 are rejected
        b3.en_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            b3.mode_i       = (i == 0) ? 2'b01 : 2'b11;
            b3.cfg_rounds_i = (i == 1) ? 4'd0 : 4'd13;
            b3.start_i      = 1'b1;
            q3.push_back(mk(K_ERR, 4'd0, 24'h0, 1'b0));
            tick();
            b3.start_i = 1'b0;
            check("u3 err ready", 32'(b3.ready_o), 32'd1);
            check("u3 err busy",  32'(b3.busy_o),  32'd0);
            tick();
            check("u3 err pulse end", 32'(b3.cfg_err_o), 32'd0);
        end
        // Unroll=3, p6 is legal
        b3.mode_i  = 2'b10;
        b3.start_i = 1'b1;
        q3.push_back(mk(K_STEP, 4'd6, 24'h788796, 1'b0));
        q3.push_back(mk(K_STEP, 4'd9, 24'h4B5A69, 1'b1));
        q3.push_back(mk(K_DONE, 4'd9, 24'h0, 1'b0));
        tick();
        b3.start_i = 1'b0;
        drain("u3_cfg");

        // Abort together with start at round 7
        b1.mode_i  = 2'b00;
        b1.en_i    = 1'b1;
        b1.start_i = 1'b1;
        for (int r = 0; r < 8; r++) q1.push_back(mk(K_STEP, 4'(r), 24'(RC_TAB[r]), 1'b0));
        tick();
        b1.start_i = 1'b0;
        repeat (7) tick();
        b1.abort_i = 1'b1;
        b1.start_i = 1'b1;
        tick();
        b1.abort_i = 1'b0;
        b1.start_i = 1'b0;
        check("abort busy",  32'(b1.busy_o),  32'd0);
        check("abort ready", 32'(b1.ready_o), 32'd1);
        check("abort rc",    32'(b1.rc_o),    32'd0);
        check("abort done",  32'(b1.done_o),  32'd0);
        drain("u1_abort");
        run_p12_u1("u1_restart");

        // Start ignored during RUN, then asynchronous reset mid-run
        b1.mode_i  = 2'b10;
        b1.en_i    = 1'b1;
        b1.start_i = 1'b1;
        for (int r = 6; r < 10; r++) q1.push_back(mk(K_STEP, 4'(r), 24'(RC_TAB[r]), 1'b0));
        tick();
        b1.start_i = 1'b0;
        tick();
        b1.start_i = 1'b1;
        b1.mode_i  = 2'b00;
        tick();
        b1.start_i = 1'b0;
        tick();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst round", 32'(b1.round_o), 32'd0);
        check("arst busy",  32'(b1.busy_o),  32'd0);
        check("arst done",  32'(b1.done_o),  32'd0);
        check("arst ready", 32'(b1.ready_o), 32'd1);
        check("arst rc",    32'(b1.rc_o),    32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        drain("u1_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ascon_round_sequencer.md
Name: ascon_round_sequencer

Overview:
- Parametrised round sequencer for the Ascon permutation core. It generalises the fixed p12/p6 counter to selectable round counts (p12, p8, p6, or a custom count) and to U rounds per step for unrolled datapaths.
- Provides a start/done handshake, a stall enable, and abort. It emits the round index and the U packed Ascon round constants that the permutation datapath consumes each step.

Parameters:
- MaxRounds, 12, total rounds of the full permutation; the last round index is MaxRounds-1.
- Unroll, 1, rounds executed per enabled step (U); legal values are 1, 2, 3.
- RndW, 4, width of round index and count fields; must satisfy 2^RndW > MaxRounds.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_n_i  in  1  reset; asynchronous, active-low.
- start_i  in  1  start request; accepted only when ready_o=1.
- mode_i  in  2  round-count select, sampled at start: 00=12, 01=8, 10=6, 11=cfg_rounds_i.
- cfg_rounds_i  in  RndW  custom round count when mode_i=11.
- en_i  in  1  step enable from the datapath; 0 stalls the sequencer.
- abort_i  in  1  synchronous abort back to IDLE.
- ready_o  out  1  1 in IDLE.
- busy_o  out  1  1 in RUN.
- round_o  out  RndW  index of the first round in the current step.
- rc_o  out  8*Unroll  packed round constants; slice k holds rc(round_o+k).
- last_o  out  1  current step is the final step.
- done_o  out  1  one-cycle pulse after the final step completes.
- cfg_err_o  out  1  one-cycle pulse when a start is rejected for an illegal count.

Behaviour:
- Reset values: state=IDLE, rnd_q=0, done_o=0, cfg_err_o=0; therefore ready_o=1, busy_o=0, last_o=0, rc_o=0.
- Round count n: 12, 8 or 6 by mode_i; for mode 11, n=cfg_rounds_i.
- n is legal iff 1<=n<=MaxRounds and n mod Unroll == 0.
- IDLE, start_i=1, abort_i=0, n legal: next cycle state=RUN and rnd_q=MaxRounds-n.
- IDLE, start_i=1, abort_i=0, n illegal: state stays IDLE; cfg_err_o=1 on the next cycle only.
- IDLE otherwise: rnd_q holds its value.
- RUN, en_i=1, not last: rnd_q += Unroll.
- RUN, en_i=0: rnd_q and state hold. Stalls may last any number of cycles.
- last_o = busy_o && (rnd_q+Unroll == MaxRounds); combinational.
- RUN, en_i=1, last_o=1: next cycle state=IDLE and done_o=1 for exactly one cycle; rnd_q holds its final value.
- Latency: start accepted at cycle t; the first step is presented at t+1. With no stalls, done_o is high at t+1+n/Unroll.
- round_o = rnd_q in all states.
- rc_o is zero in IDLE. In RUN, slice k (bits 8k+7:8k) = {4'hF - r, r} with r=rnd_q+k; e.g. r=0 gives 0xF0, r=11 gives 0x4B.
- Round arithmetic is evaluated at RndW+1 bits, so there is no wrap-around; rnd_q never exceeds MaxRounds-Unroll in RUN.
- start_i in RUN is ignored; there is no queuing.
- abort_i=1 in any state: next state=IDLE; no done_o; no cfg_err_o. Abort wins over start_i and over a completing last step.
- start_i may be asserted in the same cycle done_o is high, since the sequencer is already IDLE. Back-to-back permutations therefore cost one idle cycle.
- Reset asserted mid-RUN: immediate return to reset values; no done_o.

Test Plan:
- Unroll=1, mode=00, start then en_i held 1 -> round_o steps 0..11; rc_o steps 0xF0, 0xE1, ... 0x4B; last_o high only at round 11; done_o pulse exactly 13 cycles after the start edge.
- Unroll=1, mode=10 with en_i toggled 1,0,1,0 -> round_o visits 6..11 with each value held across the stall cycles; done_o pulses once, one cycle after round 11 is stepped.
- Unroll=2, mode=01 -> round_o = 4, 6, 8, 10; rc_o at round 4 = {0xA5, 0xB4} (slice 1 high byte); done_o after 4 enabled steps.
- Unroll=3, mode=01 (n=8), and mode=11 with cfg_rounds_i=0 or 13 -> cfg_err_o pulses 1 cycle; ready_o stays 1; busy_o stays 0.
- In RUN at round 7, assert abort_i together with start_i -> IDLE next cycle; no done_o; rc_o=0; a subsequent start with mode=00 restarts at round 0.
- Drive start_i during RUN, then assert rst_n_i=0 mid-run -> start ignored (rounds unchanged); reset forces round_o=0, busy_o=0, done_o=0 immediately.
